// File: rtl/multconst_pkg.sv
// Shared widths and helpers for the multi-lane constant multiplier.
package multconst_pkg;

  // Widest lane product and widest packed vector the helpers handle.
  localparam int MAX_W   = 64;
  localparam int VEC_MAX = 1024;

  // Result lane width after the right-shift scaling.
  function automatic int res_width(input int din, input int cw, input int sh);
    return din + cw - sh;
  endfunction

  // Extract lane `lane` of `width` bits from a packed vector (lane 0 in LSBs).
  function automatic logic [MAX_W-1:0] lane_slice(input logic [VEC_MAX-1:0] vec,
                                                  input int lane, input int width);
    logic [VEC_MAX-1:0] shifted;
    logic [MAX_W-1:0]   mask;
    shifted = vec >> (lane * width);
    mask    = {MAX_W{1'b1}} >> (MAX_W - width);
    return shifted[MAX_W-1:0] & mask;
  endfunction

  // Place a `width`-bit value at lane `lane` of an otherwise zero vector.
  function automatic logic [VEC_MAX-1:0] lane_place(input logic [MAX_W-1:0] val,
                                                    input int lane, input int width);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    return VEC_MAX'(val & mask) << (lane * width);
  endfunction

  // Round-half-up right shift. The product is far narrower than MAX_W,
  // so the rounding increment can never carry out.
  function automatic logic [MAX_W-1:0] round_shift(input logic [MAX_W-1:0] p, input int sh);
    if (sh == 0) return p;
    return (p + (MAX_W'(1) << (sh - 1))) >> sh;
  endfunction

endpackage

// File: rtl/multconst_stage.sv
// One elastic pipeline slice: data register, valid bit and advance logic.
module multconst_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_advance,
  output logic             advance,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A stage may take new data when it is empty or its content moves on;
  // this lets bubbles collapse instead of stalling a full stage.
  assign advance = !valid || next_advance;

  // Capture the upstream slot whenever this stage advances.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value, giving a true shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      // NOTE: the data register is reset too, because result must read 0
      // during reset; it is a plain register, not a memory array.
      data  <= '0;
    end else if (advance) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/multconst_pipe.sv
// Multi-lane pipelined multiply-by-constant with valid/ready handshake,
// reloadable shared constant and optional round-half-up scaling.
module multconst_pipe
  import multconst_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 16,
  parameter int CONST_WIDTH   = 18,
  parameter int CONST_DEFAULT = 78125,
  parameter int LANES         = 4,
  parameter int STAGES        = 2,
  parameter int SHIFT         = 0,
  localparam int RES_WIDTH    = res_width(DATA_IN_WIDTH, CONST_WIDTH, SHIFT)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         const_load,
  input  logic [CONST_WIDTH-1:0]       const_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DATA_IN_WIDTH-1:0] op_a,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*RES_WIDTH-1:0]   result,
  output logic                         busy
);

  localparam int PROD_WIDTH = DATA_IN_WIDTH + CONST_WIDTH;
  localparam int VEC_W      = LANES * RES_WIDTH;

  logic [CONST_WIDTH-1:0] k;
  logic [VEC_W-1:0]       scaled;
  logic [STAGES-1:0]      stage_valid;

  // Active constant; a vector accepted on a load edge still sees the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        k <= CONST_WIDTH'(CONST_DEFAULT);
    else if (const_load) k <= const_in;
  end

  // Stage-0 datapath: per-lane product with the current constant, then scaling.
  always_comb begin
    logic [VEC_MAX-1:0]    packed_v;
    logic [PROD_WIDTH-1:0] prod;
    packed_v = '0;
    prod     = '0;
    for (int i = 0; i < LANES; i++) begin
      prod     = PROD_WIDTH'(lane_slice(VEC_MAX'(op_a), i, DATA_IN_WIDTH)) * PROD_WIDTH'(k);
      packed_v = packed_v | lane_place(round_shift(MAX_W'(prod), SHIFT), i, RES_WIDTH);
    end
    scaled = packed_v[VEC_W-1:0];
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             adv;
    logic             vld;
    logic             nxt;
    logic             src_valid;
    logic [VEC_W-1:0] src_data;
    logic [VEC_W-1:0] dat;

    if (s == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_data  = scaled;
    end else begin : g_src
      assign src_valid = g_stage[s-1].vld;
      assign src_data  = g_stage[s-1].dat;
    end

    if (s == STAGES - 1) begin : g_nxt
      assign nxt = out_ready;
    end else begin : g_nxt
      assign nxt = g_stage[s+1].adv;
    end

    multconst_stage #(.WIDTH(VEC_W)) u_stage (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (src_valid),
      .in_data      (src_data),
      .next_advance (nxt),
      .advance      (adv),
      .valid        (vld),
      .data         (dat)
    );

    assign stage_valid[s] = vld;
  end

  // Ready is held low during reset even though every stage reads empty.
  assign in_ready  = reset_n && g_stage[0].adv;
  assign out_valid = g_stage[STAGES-1].vld;
  assign result    = g_stage[STAGES-1].dat;
  assign busy      = |stage_valid;

endmodule

// File: tb/tb_multconst_pipe.sv
// Scoreboard bench for multconst_pipe: default build plus a SHIFT=4 build.
module tb_multconst_pipe;

  localparam int DW     = 16;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int RW     = 34;
  localparam int RW4    = 30;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // default-parameter instance
  logic                  const_load = 1'b0;
  logic [17:0]           const_in = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*DW-1:0]   op_a = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [LANES*RW-1:0]   result;
  logic                  busy;

  // SHIFT=4 instance
  logic                  s4_const_load = 1'b0;
  logic [17:0]           s4_const_in = '0;
  logic                  s4_in_valid = 1'b0;
  logic                  s4_in_ready;
  logic [LANES*DW-1:0]   s4_op_a = '0;
  logic                  s4_out_valid;
  logic [LANES*RW4-1:0]  s4_result;
  logic                  s4_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [LANES*RW-1:0] sb[$];
  logic [17:0]         k_model = 18'd78125;
  logic                acc_now;
  logic                prev_stall = 1'b0;
  logic [LANES*RW-1:0] prev_result;

  always #5 clk = ~clk;

  multconst_pipe dut (
    .clk(clk), .reset_n(reset_n), .const_load(const_load), .const_in(const_in),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  multconst_pipe #(.SHIFT(4)) dut_s4 (
    .clk(clk), .reset_n(reset_n), .const_load(s4_const_load), .const_in(s4_const_in),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready), .op_a(s4_op_a), .out_valid(s4_out_valid),
    .out_ready(1'b1), .result(s4_result), .busy(s4_busy)
  );

  // Reference: unsigned per-lane product, no scaling (SHIFT = 0 build).
  function automatic logic [LANES*RW-1:0] model(input logic [LANES*DW-1:0] a, input logic [17:0] k);
    logic [LANES*RW-1:0] r;
    logic [63:0] p;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      p = 64'(a[DW*i +: DW]) * 64'(k);
      r[RW*i +: RW] = p[RW-1:0];
    end
    return r;
  endfunction

  // One clock of handshake traffic with full scoreboard checking.
  task automatic drive_cycle(input logic iv, input logic [LANES*DW-1:0] a, input logic ordy,
                             input logic cl, input logic [17:0] ci);
    logic exp_rdy;
    logic [LANES*RW-1:0] exp;
    @(negedge clk);
    in_valid = iv; op_a = a; out_ready = ordy; const_load = cl; const_in = ci;
    #1;
    acc_now = 1'b0;
    if (prev_stall) begin
      vectors++;
      if (!out_valid || result !== prev_result) begin
        miscompares++;
        $display("FAIL stall_hold: out_valid=%b result=%h, required out_valid=1 result=%h",
                 out_valid, result, prev_result);
      end
    end
    exp_rdy = (sb.size() < STAGES) || ordy;
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL in_ready: got %b, required %b (held=%0d out_ready=%b)",
               in_ready, exp_rdy, sb.size(), ordy);
    end
    if (out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: result=%h, required no output", result);
      end else begin
        exp = sb.pop_front();
        if (result !== exp) begin
          miscompares++;
          $display("FAIL result: got %h, required %h", result, exp);
        end
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(a, k_model));
      acc_now = 1'b1;
    end
    if (const_load) k_model = ci;
    prev_stall  = out_valid && !out_ready;
    prev_result = result;
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() > 0 && c < 50) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
      c++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d vectors outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, required 0 0 0 0",
               in_ready, out_valid, busy, result);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_defaults();
    int cnt = 0;
    logic [LANES*RW-1:0] exp;
    exp = {34'd234375, 34'd156250, 34'd78125, 34'd5119921875};
    @(negedge clk);
    in_valid = 1'b1; op_a = {16'd3, 16'd2, 16'd1, 16'hFFFF}; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept: got %b, required 1", busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    vectors++;
    if (cnt != STAGES - 1) begin
      miscompares++;
      $display("FAIL latency: got %0d extra edges, required %0d", cnt, STAGES - 1);
    end
    vectors++;
    if (result !== exp) begin
      miscompares++;
      $display("FAIL default_product: got %h, required %h", result, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_shift_round(input logic [17:0] kk, input logic [15:0] a, input logic [29:0] lane_exp);
    logic seen = 1'b0;
    logic [LANES*RW4-1:0] got = '0;
    @(negedge clk);
    s4_const_load = 1'b1; s4_const_in = kk;
    @(negedge clk);
    s4_const_load = 1'b0; s4_in_valid = 1'b1; s4_op_a = {LANES{a}};
    @(negedge clk);
    s4_in_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (s4_out_valid) begin seen = 1'b1; got = s4_result; end
      else @(negedge clk);
    end
    vectors++;
    if (!seen || got !== {LANES{lane_exp}}) begin
      miscompares++;
      $display("FAIL shift_round k=%0d a=%0d: seen=%b got %h, required %h",
               kk, a, seen, got, {LANES{lane_exp}});
    end
    @(negedge clk);
  endtask

  task automatic test_const_same_cycle();
    drive_cycle(1'b1, {LANES{16'd2}}, 1'b1, 1'b1, 18'd3);
    drive_cycle(1'b1, {LANES{16'd2}}, 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [LANES*DW-1:0] vec[10];
    int idx = 0;
    for (int i = 0; i < 10; i++) vec[i] = {$urandom, $urandom};
    for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
      drive_cycle(1'b1, vec[idx], (cyc % 3) == 0, 1'b0, '0);
      if (acc_now) idx++;
    end
    vectors++;
    if (idx != 10) begin
      miscompares++;
      $display("FAIL back_to_back_accept: accepted %0d, required 10", idx);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 18'd5);
    drive_cycle(1'b1, {LANES{16'd9}}, 1'b0, 1'b0, '0);
    drive_cycle(1'b1, {LANES{16'd7}}, 1'b0, 1'b0, '0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midflight: out_valid=%b busy=%b in_ready=%b, required 0 0 0",
               out_valid, busy, in_ready);
    end
    sb.delete();
    k_model = 18'd78125;
    prev_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
    drive_cycle(1'b1, {LANES{16'd1}}, 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_random();
    logic [LANES*DW-1:0] a;
    for (int c = 0; c < 10000; c++) begin
      for (int l = 0; l < LANES; l++) begin
        case ($urandom_range(0, 3))
          0:       a[DW*l +: DW] = '0;
          1:       a[DW*l +: DW] = '1;
          default: a[DW*l +: DW] = DW'($urandom);
        endcase
      end
      drive_cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, 18'($urandom));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_shift_round(18'd8, 16'd1, 30'd1);
    test_shift_round(18'd7, 16'd1, 30'd0);
    test_shift_round(18'd24, 16'd1, 30'd2);
    test_shift_round(18'h3FFFF, 16'hFFFF, 30'd1073721344);
    test_const_same_cycle();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multconst_pipe.md
# multconst_pipe

Multi-lane, pipelined multiply-by-constant unit with a valid/ready handshake, a runtime-reloadable constant, and optional round-to-nearest right-shift scaling. It is the next generation of the fixed single-lane registered constant multiplier, and sits in the TPU datapath wherever an operand vector is scaled by a shared constant (normalisation, fixed-point rescale). Unlike the fixed multiplier, it sustains one vector per cycle under downstream backpressure without dropping or duplicating data.

## Interface
Parameters:
- DATA_IN_WIDTH, 16, unsigned operand width per lane
- CONST_WIDTH, 18, unsigned constant width
- CONST_DEFAULT, 78125, constant value loaded at reset
- LANES, 4, number of parallel lanes sharing one constant
- STAGES, 2, pipeline register stages (≥1)
- SHIFT, 0, right-shift applied to each product (0 ≤ SHIFT < DATA_IN_WIDTH)
- RES_WIDTH (derived), DATA_IN_WIDTH+CONST_WIDTH−SHIFT

Ports:
- clk  in  1  the block's one clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- const_load  in  1  load const_in into the active constant register
- const_in  in  CONST_WIDTH  new constant value
- in_valid  in  1  op_a holds a valid vector
- in_ready  out  1  block accepts the vector this cycle
- op_a  in  LANES*DATA_IN_WIDTH  operand vector, lane 0 in the LSBs
- out_valid  out  1  result holds a valid vector
- out_ready  in  1  downstream accepts result this cycle
- result  out  LANES*RES_WIDTH  scaled product vector, lane 0 in the LSBs
- busy  out  1  at least one pipeline stage holds valid data

## Operation
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Per lane: p = op_a[i] * K, unsigned, full width DATA_IN_WIDTH+CONST_WIDTH. K is the constant register value in the acceptance cycle.
- Scaling when SHIFT = 0: result = p.
- Scaling when SHIFT > 0: result = (p + 2^(SHIFT−1)) >> SHIFT, which rounds half up. The addition cannot overflow the full product width, so there is no saturation logic.
- The multiply happens in stage 0, so in-flight vectors are never affected by a later constant load.
- Constant register:
  - Reset value is CONST_DEFAULT.
  - When const_load is high at a clock edge, K takes const_in at that edge.
  - A vector accepted in the same cycle as const_load uses the old K.
- Pipeline: STAGES stages, each holding a data register and a valid bit.
  - Stage s advances when it is empty, or when stage s+1 advances. For the last stage, "s+1 advances" means out_ready is high.
  - Bubbles collapse: a full stage never waits behind an empty one.
- in_ready = !valid[0] || advance[0]. It is combinational from out_ready through the advance chain and never depends on in_valid.
- out_valid = valid[STAGES−1]. result is the last-stage data register.
- While out_valid && !out_ready, result and out_valid hold stable.
- busy = OR of all stage valid bits.

## Timing
- Reset (reset_n low, asynchronous):
  - all valid bits = 0, out_valid = 0, result = 0, busy = 0, K = CONST_DEFAULT
  - in_ready = 0 while reset_n is low
  - in_ready = 1 from the first cycle after deassertion
- Latency: a vector accepted at edge n appears with out_valid = 1 after edge n+STAGES−1 (first observable in cycle n+STAGES−1), given no backpressure.
- Throughput: one vector per cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0. Exactly STAGES vectors are held, with no loss and no duplication.
- out_ready rising with the pipeline full: in_ready = 1 in the same cycle, so accept and deliver happen simultaneously.
- Reset mid-operation: all in-flight vectors are discarded and K returns to CONST_DEFAULT. No partial vector is emitted.
- const_load is allowed every cycle. When consecutive loads occur, the last one wins.

## Structure
- Package multconst_pkg holds:
  - the RES_WIDTH computation
  - the lane slice/pack helper functions
  - the round-shift function (p, SHIFT) → RES_WIDTH
- One sub-module, multconst_stage: a single pipeline register slice (data + valid, advance logic). It is instantiated STAGES times in a generate loop.
- Stage 0 additionally computes the LANES products and applies the rounding before registering.

## Test plan
- Defaults, lane 0 = 65535, others 1, 2, 3; out_ready = 1 → after STAGES cycles, lane 0 = 5119921875 and lanes 1–3 = 78125, 156250, 234375.
- SHIFT = 4 build, const_load K = 8 then op_a = 1 → result 1. Repeat with K = 7 → result 0 (half-up boundary: 15 >> 4).
- Stream 10 back-to-back vectors with out_ready toggling 1, 0, 0, 1, … → outputs are in order and complete; result is stable while stalled; in_ready = 0 exactly when STAGES vectors are held.
- const_load K = 3 in the same cycle as accepting op_a = 2, then accept op_a = 2 again → outputs 156250 then 6.
- Reset pulsed with 2 vectors in flight → out_valid and busy drop immediately; no output after release; K = 78125; in_ready = 1 on the next cycle.
- Random vectors and constants against a reference model for 10k cycles with random backpressure → bit-exact results and order, including operand values 0 and max.
